synapse_weight_streamer: RTL
============================

Name: synapse_weight_streamer

Overview:
- Weight-fetch front end that drives the control and data inputs of the neuron accumulator (mac_unit).
- For one neuron it latches a spike bitmap of presynaptic inputs and scans it lowest index first.
- For each set bit it reads one weight from synapse memory (synchronous read) and presents it with an accumulate strobe.
- Brackets each pass with a clear pulse at the start and a done pulse at the end, for main_ctrl.

Parameters:
- NUM_INPUTS, 16, number of presynaptic inputs (spike bitmap width), >=2
- DATA_WIDTH, 8, weight width; matches the accumulator data width
- ADDR_WIDTH, 10, synapse memory address width
- IDX_WIDTH, $clog2(NUM_INPUTS), input index width (derived localparam)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle request; sampled only in IDLE
- i_spikes  in  NUM_INPUTS  spike bitmap; latched when i_start is accepted
- i_base_addr  in  ADDR_WIDTH  base address of this neuron's weight row; latched with i_start
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse; accumulator sum is valid in this cycle
- o_mem_rd_en  out  1  synapse memory read enable
- o_mem_addr  out  ADDR_WIDTH  read address
- i_mem_rdata  in  DATA_WIDTH  read data, valid one cycle after o_mem_rd_en
- o_clear  out  1  accumulator clear pulse
- o_accumulate  out  1  accumulator enable
- o_weight  out  DATA_WIDTH  weight to accumulator (combinational pass-through of i_mem_rdata)

Behaviour:
- Reset (async, rst=1): state goes to IDLE. o_busy, o_done, o_mem_rd_en, o_clear and o_accumulate are 0. o_mem_addr is 0. Latched mask and base are 0. Any in-flight read is discarded and no accumulate follows.
- FSM states: IDLE, CLEAR, SCAN, DRAIN, DONE.
- IDLE: if i_start=1, latch i_spikes into the mask register and latch i_base_addr, then go to CLEAR. i_start in any other state is ignored with no side effect.
- CLEAR: o_clear=1 for exactly one cycle.
  - Mask all zero: go to DONE.
  - Otherwise: go to SCAN.
- SCAN: each cycle a priority encoder selects the lowest set mask bit, idx.
  - Drive o_mem_rd_en=1 and o_mem_addr = base + idx. The address is truncated to ADDR_WIDTH and wraps modulo 2^ADDR_WIDTH.
  - Clear that mask bit.
  - If the mask becomes zero, go to DRAIN; otherwise stay in SCAN.
- Accumulate timing: o_accumulate is o_mem_rd_en delayed by one register stage. o_weight = i_mem_rdata, so every read produces exactly one accumulate one cycle later.
- DRAIN: one cycle; the accumulate for the last weight occurs here. Then go to DONE.
- DONE: o_done=1 for one cycle, then go to IDLE. o_busy is still 1 in DONE.
- Latency, with i_start accepted at edge T and k = popcount(i_spikes):
  - k=0: o_clear at T+1, o_done at T+2, no reads.
  - k>=1: o_clear at T+1; reads at T+2..T+1+k; accumulates at T+3..T+2+k; o_done at T+3+k.
- o_clear and o_accumulate are never high in the same cycle.
- Throughput: one weight per cycle; back-to-back neurons are separated by at least one IDLE cycle.
- All-ones mask: NUM_INPUTS consecutive reads at base..base+NUM_INPUTS-1, in index order.
- Rst asserted mid-SCAN: outputs drop asynchronously. After release, no o_done or o_accumulate appears until a new i_start.

Optional Feature:
- Macro: SPIKE_COUNT_EN.
- When defined: adds output port o_spike_count, width $clog2(NUM_INPUTS+1).
  - Cleared on reset and when i_start is accepted.
  - Incremented on each o_mem_rd_en.
  - Holds its final value from the o_done cycle until the next accepted start.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then i_start with i_spikes=16'h0000 -> o_clear at T+1, o_done at T+2, o_mem_rd_en never asserted, o_accumulate never asserted.
- i_spikes=16'h8421, base=10'h100 -> reads at addr 0x100, 0x105, 0x10A, 0x10F on consecutive cycles. Memory returns 3,5,7,9 -> accumulate strobes carry 3,5,7,9; o_done at T+7; mac sum=24.
- i_spikes=16'hFFFF, base=10'h3F8 -> 16 consecutive reads, addresses wrap 0x3F8..0x3FF then 0x000..0x007; o_done at T+19.
- i_start pulsed again during SCAN with a different bitmap -> ignored; address sequence and o_done timing unchanged.
- rst asserted after the second read of a 4-spike pass -> o_busy, o_mem_rd_en and o_accumulate go low immediately. No o_done occurs. A new start after release completes normally.
- SPIKE_COUNT_EN defined, i_spikes=16'h0F0F -> o_spike_count=8 at o_done and held; the next start with 16'h0001 gives 1.

Source files
------------

// File: rtl/synapse_weight_streamer_if.sv
// Control, synapse-memory and accumulator signals of synapse_weight_streamer.
// slave: the streamer side. master: main_ctrl / memory / accumulator side.
interface synapse_weight_streamer_if #(
  parameter int NUM_INPUTS = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  i_start;
  logic [NUM_INPUTS-1:0] i_spikes;
  logic [ADDR_WIDTH-1:0] i_base_addr;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_mem_rd_en;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] i_mem_rdata;
  logic                  o_clear;
  logic                  o_accumulate;
  logic [DATA_WIDTH-1:0] o_weight;

  modport slave (
    input  i_start, i_spikes, i_base_addr, i_mem_rdata,
    output o_busy, o_done, o_mem_rd_en, o_mem_addr, o_clear, o_accumulate, o_weight
  );

  modport master (
    output i_start, i_spikes, i_base_addr, i_mem_rdata,
    input  o_busy, o_done, o_mem_rd_en, o_mem_addr, o_clear, o_accumulate, o_weight
  );
endinterface

// File: rtl/synapse_weight_streamer.sv
// Weight-fetch front end for the neuron accumulator: scans a latched spike bitmap
// lowest index first, one synapse read per set bit. Optional SPIKE_COUNT_EN adds o_spike_count.
module synapse_weight_streamer #(
  parameter  int NUM_INPUTS = 16,
  parameter  int DATA_WIDTH = 8,
  parameter  int ADDR_WIDTH = 10,
  localparam int IDX_WIDTH  = $clog2(NUM_INPUTS),
  localparam int CNT_W      = $clog2(NUM_INPUTS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  synapse_weight_streamer_if.slave sw
`ifdef SPIKE_COUNT_EN
  ,
  output logic [CNT_W-1:0]        o_spike_count
`endif
);

  typedef enum logic [2:0] {IDLE, CLEAR, SCAN, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [NUM_INPUTS-1:0] mask_q;
  logic [NUM_INPUTS-1:0] mask_rest;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [IDX_WIDTH-1:0]  idx;
  logic                  start_acc;
  logic                  rd_en;
  logic                  acc_q;

  // Lowest set bit wins: scanning downward leaves the smallest index last.
  always_comb begin
    idx = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--)
      if (mask_q[i]) idx = IDX_WIDTH'(i);
  end

  assign mask_rest = mask_q & (mask_q - NUM_INPUTS'(1));
  assign start_acc = (state_q == IDLE) && sw.i_start;
  assign rd_en     = (state_q == SCAN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sw.i_start) state_d = CLEAR;
      CLEAR:   state_d = (mask_q == '0) ? DONE : SCAN;
      SCAN:    if (mask_rest == '0) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      base_q  <= '0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= rd_en;
      if (start_acc) begin
        mask_q <= sw.i_spikes;
        base_q <= sw.i_base_addr;
      end else if (rd_en) begin
        mask_q <= mask_rest;
      end
    end
  end

  // Status decodes straight off the state register so reset drops them at once.
  assign sw.o_busy       = (state_q != IDLE);
  assign sw.o_done       = (state_q == DONE);
  assign sw.o_clear      = (state_q == CLEAR);
  assign sw.o_mem_rd_en  = rd_en;
  assign sw.o_mem_addr   = rd_en ? (base_q + ADDR_WIDTH'(idx)) : '0;
  assign sw.o_accumulate = acc_q;
  assign sw.o_weight     = sw.i_mem_rdata;

`ifdef SPIKE_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            o_spike_count <= '0;
    else if (start_acc) o_spike_count <= '0;
    else if (rd_en)     o_spike_count <= o_spike_count + CNT_W'(1);
  end
`endif

endmodule
